// File: rtl/bus_dma_pkg.sv
// Shared definitions for the bus_dma block-copy initiator.
// State encoding and bus word geometry.
package bus_dma_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_READ  = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam int          WORD_BYTES = 4;
    localparam logic [31:0] WORD_STEP  = 32'(WORD_BYTES);

    function automatic logic [31:0] word_align(input logic [31:0] byte_addr);
        return {byte_addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/bus_dma.sv
// Block-copy bus initiator: arbitrates for the CPU data bus, then alternates
// one read and one write per word until the latched count is exhausted.
module bus_dma
    import bus_dma_pkg::*;
#(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [31:0]          src_addr,
    input  logic [31:0]          dst_addr,
    input  logic [CNT_WIDTH-1:0] word_count,
    output logic                 bus_req,
    input  logic                 bus_gnt,
    output logic                 MemRead,
    output logic                 MemWrite,
    output logic [31:0]          address,
    output logic [31:0]          write_data,
    input  logic [31:0]          read_data,
    output logic                 busy,
    output logic                 done,
    output logic                 IRQ,
    input  logic                 irq_clr
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    state_t                 state_q, state_d;
    logic [31:0]            src_q, src_d;
    logic [31:0]            dst_q, dst_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic [31:0]            data_q, data_d;

    logic                   bus_req_q, bus_req_d;
    logic                   mem_read_q, mem_read_d;
    logic                   mem_write_q, mem_write_d;
    logic [31:0]            address_q, address_d;
    logic [31:0]            write_data_q, write_data_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   irq_q, irq_d;

    // Byte-offset bits of the addresses are dropped on purpose.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{src_addr[1:0], dst_addr[1:0]};

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        cnt_d   = cnt_q;
        data_d  = data_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (word_count != '0) begin
                        src_d   = word_align(src_addr);
                        dst_d   = word_align(dst_addr);
                        cnt_d   = word_count;
                        state_d = ST_REQ;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_REQ: begin
                if (bus_gnt) begin
                    state_d = ST_READ;
                end
            end
            ST_READ: begin
                data_d  = read_data;
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                src_d   = src_q + WORD_STEP;
                dst_d   = dst_q + WORD_STEP;
                cnt_d   = cnt_q - CNT_ONE;
                state_d = (cnt_q == CNT_ONE) ? ST_DONE : ST_READ;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are registered, so they are decoded from the next state
        // and the already-updated pointers to line up with state_q.
        bus_req_d    = (state_d == ST_REQ) || (state_d == ST_READ) || (state_d == ST_WRITE);
        mem_read_d   = (state_d == ST_READ);
        mem_write_d  = (state_d == ST_WRITE);
        address_d    = (state_d == ST_READ)  ? src_d :
                       (state_d == ST_WRITE) ? dst_d : 32'h0;
        write_data_d = (state_d == ST_WRITE) ? data_d : 32'h0;
        done_d       = (state_d == ST_DONE);
        busy_d       = bus_req_d || ((state_d == ST_DONE) && (state_q == ST_WRITE));
        // A completion in progress beats a simultaneous clear.
        irq_d        = (state_q == ST_DONE) || (irq_q && !irq_clr);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            src_q        <= '0;
            dst_q        <= '0;
            cnt_q        <= '0;
            data_q       <= '0;
            bus_req_q    <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            address_q    <= '0;
            write_data_q <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            irq_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            src_q        <= src_d;
            dst_q        <= dst_d;
            cnt_q        <= cnt_d;
            data_q       <= data_d;
            bus_req_q    <= bus_req_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            address_q    <= address_d;
            write_data_q <= write_data_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            irq_q        <= irq_d;
        end
    end

    assign bus_req    = bus_req_q;
    assign MemRead    = mem_read_q;
    assign MemWrite   = mem_write_q;
    assign address    = address_q;
    assign write_data = write_data_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign IRQ        = irq_q;

endmodule
